// File: rtl/bip_fetch_control_pkg.sv
// rtl/bip_fetch_control_pkg.sv - opcodes, select encodings, FSM states and strobe bundle for the sequencer
package bip_fetch_control_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPW-1:0] OP_STO  = 5'b00001;
  localparam logic [OPW-1:0] OP_LD   = 5'b00010;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPW-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT_STEP,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       wr_ram;
    logic       rd_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to datapath strobe decode
module bip_decoder
  import bip_fetch_control_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_STO: ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_RAM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SEL_A_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADDI: begin
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.wr_acc = 1'b1;
      end
      OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.alu_op = 1'b1;
        ctrl.wr_acc = 1'b1;
      end
      OP_SUBI: begin
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.alu_op = 1'b1;
        ctrl.wr_acc = 1'b1;
      end
      // HLT and the whole 01000-11111 range carry no strobes
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_fetch_control.sv
// rtl/bip_fetch_control.sv - PC/IR/cycle counter and fetch-exec FSM with single-step support
module bip_fetch_control
  import bip_fetch_control_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic [DB-1:0] pm_data,
  output logic [AB-1:0] pm_addr,
  output logic [AB-1:0] operand,
  output logic          wr_ram,
  output logic          rd_ram,
  output logic [1:0]    sel_a,
  output logic          sel_b,
  output logic          alu_op,
  output logic          wr_acc,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] cycles
);

  state_e        state_q, state_d;
  logic [AB-1:0] pc_q, pc_d;
  logic [DB-1:0] ir_q, ir_d;
  logic [CW-1:0] cycles_q, cycles_d;
  ctrl_t         dec_ctrl;
  ctrl_t         ctrl;
  logic [OPW-1:0] opcode;

  assign opcode = ir_q[DB-1 -: OPW];

  bip_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cycles_d = cycles_q;
    if ((state_q == ST_FETCH || state_q == ST_EXEC) && cycles_q != '1) begin
      cycles_d = cycles_q + CW'(1);
    end
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d     = '0;
          cycles_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = pm_data;
        pc_d    = pc_q + AB'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == OP_HLT) begin
          state_d = ST_HALT;
        end else if (step_mode) begin
          state_d = ST_WAIT_STEP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT_STEP: begin
        // dropping step_mode while parked acts as an implicit release
        if (step || !step_mode) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cycles_q <= cycles_d;
    end
  end

  // strobes are gated by the registered state so reset clears them directly
  assign ctrl    = (state_q == ST_EXEC) ? dec_ctrl : '0;
  assign wr_ram  = ctrl.wr_ram;
  assign rd_ram  = ctrl.rd_ram;
  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign alu_op  = ctrl.alu_op;
  assign wr_acc  = ctrl.wr_acc;

  assign pm_addr = pc_q;
  assign operand = ir_q[AB-1:0];
  assign busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WAIT_STEP);
  assign halted  = (state_q == ST_HALT);
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_bip_fetch_control.sv
// tb/tb_bip_fetch_control.sv - randomized self-checking bench against an instruction-level reference model
module tb_bip_fetch_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [15:0] pm_data;
  logic [10:0] pm_addr;
  logic [10:0] operand;
  logic        wr_ram, rd_ram;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, wr_acc;
  logic        busy, halted;
  logic [31:0] cycles;
  logic [6:0]  strobes;

  logic [15:0] mem [0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  bip_fetch_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .pm_data   (pm_data),
    .pm_addr   (pm_addr),
    .operand   (operand),
    .wr_ram    (wr_ram),
    .rd_ram    (rd_ram),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .alu_op    (alu_op),
    .wr_acc    (wr_acc),
    .busy      (busy),
    .halted    (halted),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  assign pm_data = mem[pm_addr];
  assign strobes = {wr_ram, rd_ram, sel_a, sel_b, alu_op, wr_acc};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // {wr_ram, rd_ram, sel_a[1:0], sel_b, alu_op, wr_acc} from the instruction table
  function automatic logic [6:0] ref_strobes(input logic [15:0] w);
    case (w[15:11])
      5'd1:    return 7'b1000000;
      5'd2:    return 7'b0100001;
      5'd3:    return 7'b0001001;
      5'd4:    return 7'b0110001;
      5'd5:    return 7'b0010101;
      5'd6:    return 7'b0110011;
      5'd7:    return 7'b0010111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [4:0]  op;
    logic [10:0] opd;
    op  = 5'($urandom_range(1, 31));
    opd = 11'($urandom_range(0, 2047));
    return {op, opd};
  endfunction

  task automatic load_random_program(input int len);
    for (int a = 0; a < len; a++) mem[a] = rand_instr();
    mem[len] = {5'b00000, 11'($urandom_range(0, 2047))};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({pm_addr, operand, strobes, busy, halted, cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got addr=%0d opd=%0d strb=%b busy=%b halt=%b cyc=%0d want all 0",
               pm_addr, operand, strobes, busy, halted, cycles);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if ({pm_addr, operand, strobes, busy, halted, cycles} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs[%0d]: got addr=%0d opd=%0d strb=%b busy=%b halt=%b cyc=%0d want all 0",
                 i, pm_addr, operand, strobes, busy, halted, cycles);
      end
    end
  endtask

  task automatic test_program();
    logic [6:0]  exp_s [4];
    logic [10:0] exp_o [4];
    exp_s = '{7'b0001001, 7'b0010101, 7'b1000000, 7'b0000000};
    exp_o = '{11'd5, 11'd3, 11'd7, 11'd0};
    mem[0] = {5'd3, 11'd5};
    mem[1] = {5'd5, 11'd3};
    mem[2] = {5'd1, 11'd7};
    mem[3] = 16'h0000;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({busy, halted, strobes, pm_addr} !== {1'b1, 1'b0, 7'b0, 11'(i)}) begin
        n_fail++;
        $display("FAIL program_fetch[%0d]: got busy=%b halt=%b strb=%b addr=%0d want 1/0/0/%0d",
                 i, busy, halted, strobes, pm_addr, i);
      end
      tick();
      n_tests++;
      if ({strobes, operand} !== {exp_s[i], exp_o[i]}) begin
        n_fail++;
        $display("FAIL program_exec[%0d]: got strb=%b opd=%0d want strb=%b opd=%0d",
                 i, strobes, operand, exp_s[i], exp_o[i]);
      end
      tick();
    end
    n_tests++;
    if ({halted, busy, strobes, pm_addr, cycles} !== {1'b1, 1'b0, 7'b0, 11'd4, 32'd8}) begin
      n_fail++;
      $display("FAIL program_halt: got halt=%b busy=%b strb=%b addr=%0d cyc=%0d want 1/0/0/4/8",
               halted, busy, strobes, pm_addr, cycles);
    end
  endtask

  task automatic test_random_free_run();
    logic [10:0] pc;
    logic [15:0] w;
    int          cyc;
    int          len;
    for (int rep = 0; rep < 4; rep++) begin
      len = $urandom_range(4, 16);
      load_random_program(len);
      pc  = '0;
      cyc = 0;
      pulse_start();
      for (int k = 0; k <= len; k++) begin
        w = mem[pc];
        n_tests++;
        if ({busy, halted, strobes, pm_addr} !== {1'b1, 1'b0, 7'b0, pc}) begin
          n_fail++;
          $display("FAIL rand_fetch[%0d.%0d]: got busy=%b halt=%b strb=%b addr=%0d want addr=%0d",
                   rep, k, busy, halted, strobes, pm_addr, pc);
        end
        pc  = pc + 11'd1;
        cyc = cyc + 2;
        tick();
        n_tests++;
        if ({strobes, operand} !== {ref_strobes(w), w[10:0]}) begin
          n_fail++;
          $display("FAIL rand_exec[%0d.%0d]: got strb=%b opd=%0d want strb=%b opd=%0d",
                   rep, k, strobes, operand, ref_strobes(w), w[10:0]);
        end
        tick();
        if (w[15:11] == 5'd0) break;
      end
      n_tests++;
      if ({halted, busy, pm_addr, cycles} !== {1'b1, 1'b0, pc, 32'(cyc)}) begin
        n_fail++;
        $display("FAIL rand_halt[%0d]: got halt=%b busy=%b addr=%0d cyc=%0d want 1/0/%0d/%0d",
                 rep, halted, busy, pm_addr, cycles, pc, cyc);
      end
    end
  endtask

  task automatic test_step_mode();
    logic [10:0] pc;
    logic [15:0] w;
    int          cyc;
    int          len;
    int          gap;
    len = $urandom_range(4, 7);
    load_random_program(len);
    pc        = '0;
    cyc       = 0;
    step_mode = 1'b1;
    pulse_start();
    for (int k = 0; k <= len; k++) begin
      w    = mem[pc];
      step = 1'($urandom_range(0, 1));
      n_tests++;
      if ({busy, halted, strobes, pm_addr} !== {1'b1, 1'b0, 7'b0, pc}) begin
        n_fail++;
        $display("FAIL step_fetch[%0d]: got busy=%b halt=%b strb=%b addr=%0d want addr=%0d",
                 k, busy, halted, strobes, pm_addr, pc);
      end
      pc   = pc + 11'd1;
      cyc  = cyc + 2;
      tick();
      step = 1'($urandom_range(0, 1));
      n_tests++;
      if ({strobes, operand} !== {ref_strobes(w), w[10:0]}) begin
        n_fail++;
        $display("FAIL step_exec[%0d]: got strb=%b opd=%0d want strb=%b opd=%0d",
                 k, strobes, operand, ref_strobes(w), w[10:0]);
      end
      tick();
      step = 1'b0;
      if (w[15:11] == 5'd0) break;
      gap = $urandom_range(2, 4);
      for (int g = 0; g < gap; g++) begin
        n_tests++;
        if ({busy, halted, strobes, pm_addr, cycles} !== {1'b1, 1'b0, 7'b0, pc, 32'(cyc)}) begin
          n_fail++;
          $display("FAIL step_wait[%0d.%0d]: got busy=%b halt=%b strb=%b addr=%0d cyc=%0d want 1/0/0/%0d/%0d",
                   k, g, busy, halted, strobes, pm_addr, cycles, pc, cyc);
        end
        tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        step = 1'b1;
        tick();
        step = 1'b0;
      end else begin
        step_mode = 1'b0;
        tick();
        step_mode = 1'b1;
      end
    end
    n_tests++;
    if ({halted, busy, pm_addr, cycles} !== {1'b1, 1'b0, pc, 32'(cyc)}) begin
      n_fail++;
      $display("FAIL step_halt: got halt=%b busy=%b addr=%0d cyc=%0d want 1/0/%0d/%0d",
               halted, busy, pm_addr, cycles, pc, cyc);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_wrap();
    logic [10:0] pc;
    logic [15:0] w;
    int          cyc;
    for (int a = 0; a < 2048; a++) mem[a] = {5'b01100, 11'($urandom_range(0, 2047))};
    pc  = '0;
    cyc = 0;
    pulse_start();
    for (int k = 0; k < 2100; k++) begin
      if (pc == 11'd2046) mem[0] = 16'h0000;
      w = mem[pc];
      n_tests++;
      if ({busy, strobes, pm_addr} !== {1'b1, 7'b0, pc}) begin
        n_fail++;
        $display("FAIL wrap_fetch[%0d]: got busy=%b strb=%b addr=%0d want addr=%0d",
                 k, busy, strobes, pm_addr, pc);
      end
      pc  = pc + 11'd1;
      cyc = cyc + 2;
      tick();
      n_tests++;
      if ({strobes, operand} !== {ref_strobes(w), w[10:0]}) begin
        n_fail++;
        $display("FAIL wrap_exec[%0d]: got strb=%b opd=%0d want strb=%b opd=%0d",
                 k, strobes, operand, ref_strobes(w), w[10:0]);
      end
      tick();
      if (w[15:11] == 5'd0) break;
    end
    n_tests++;
    if ({halted, pm_addr, cycles} !== {1'b1, 11'd1, 32'd4098}) begin
      n_fail++;
      $display("FAIL wrap_halt: got halt=%b addr=%0d cyc=%0d want 1/1/4098", halted, pm_addr, cycles);
    end
  endtask

  task automatic test_start_busy_restart();
    logic [10:0] pc;
    logic [15:0] w;
    int          cyc;
    load_random_program(6);
    for (int pass = 0; pass < 2; pass++) begin
      pc  = '0;
      cyc = 0;
      pulse_start();
      n_tests++;
      if ({busy, halted, pm_addr, cycles} !== {1'b1, 1'b0, 11'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL restart[%0d]: got busy=%b halt=%b addr=%0d cyc=%0d want 1/0/0/0",
                 pass, busy, halted, pm_addr, cycles);
      end
      for (int k = 0; k <= 6; k++) begin
        w     = mem[pc];
        start = 1'($urandom_range(0, 1));
        n_tests++;
        if ({strobes, pm_addr} !== {7'b0, pc}) begin
          n_fail++;
          $display("FAIL busy_start_fetch[%0d.%0d]: got strb=%b addr=%0d want 0/%0d",
                   pass, k, strobes, pm_addr, pc);
        end
        pc  = pc + 11'd1;
        cyc = cyc + 2;
        tick();
        start = 1'($urandom_range(0, 1));
        n_tests++;
        if ({strobes, operand} !== {ref_strobes(w), w[10:0]}) begin
          n_fail++;
          $display("FAIL busy_start_exec[%0d.%0d]: got strb=%b opd=%0d want strb=%b opd=%0d",
                   pass, k, strobes, operand, ref_strobes(w), w[10:0]);
        end
        tick();
        start = 1'b0;
        if (w[15:11] == 5'd0) break;
      end
      n_tests++;
      if ({halted, pm_addr, cycles} !== {1'b1, pc, 32'(cyc)}) begin
        n_fail++;
        $display("FAIL busy_start_halt[%0d]: got halt=%b addr=%0d cyc=%0d want 1/%0d/%0d",
                 pass, halted, pm_addr, cycles, pc, cyc);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    mem[0] = {5'd4, 11'd9};
    pulse_start();
    tick();
    n_tests++;
    if ({strobes, operand} !== {7'b0110001, 11'd9}) begin
      n_fail++;
      $display("FAIL add_exec: got strb=%b opd=%0d want 0110001/9", strobes, operand);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pm_addr, operand, strobes, busy, halted, cycles} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got addr=%0d opd=%0d strb=%b busy=%b halt=%b cyc=%0d want all 0",
               pm_addr, operand, strobes, busy, halted, cycles);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({pm_addr, strobes, busy, halted} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got addr=%0d strb=%b busy=%b halt=%b want all 0",
               pm_addr, strobes, busy, halted);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    rst_n     = 1'b0;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    test_reset();
    test_program();
    test_random_free_run();
    test_step_mode();
    test_wrap();
    test_start_busy_restart();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
